// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory slave port between the
// instruction fetch unit (read-only) and the load/store unit (read/write).
// One transaction is in flight at a time. A watchdog forces an error response
// when the slave fails to accept or answer within TIMEOUT cycles.
module mem_arbiter #(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                i_clock,
  input  logic                i_reset,
  // instruction fetch unit (read-only)
  input  logic                i_ifu_req,
  input  logic [ADDR_W-1:0]   i_ifu_addr,
  output logic                o_ifu_resp_valid,
  output logic [DATA_W-1:0]   o_ifu_rdata,
  output logic                o_ifu_err,
  // load/store unit
  input  logic                i_lsu_req,
  input  logic                i_lsu_wen,
  input  logic [ADDR_W-1:0]   i_lsu_addr,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_wmask,
  output logic                o_lsu_resp_valid,
  output logic [DATA_W-1:0]   o_lsu_rdata,
  output logic                o_lsu_err,
  // memory slave port
  output logic                o_mem_req_valid,
  input  logic                i_mem_req_ready,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_wen,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wmask,
  input  logic                i_mem_resp_valid,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  localparam int MASK_W = DATA_W / 8;
  // Wide enough to hold TIMEOUT itself so the saturating counter never wraps.
  localparam int CNT_W  = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_reg;
  logic                owner_ifu_reg;       // 1 = IFU owns the transaction, 0 = LSU
  logic                last_owner_ifu_reg;  // owner of the most recent grant
  logic [CNT_W-1:0]    cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                wen_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [MASK_W-1:0]   wmask_reg;
  logic                mem_req_valid_reg;
  logic                ifu_resp_valid_reg;
  logic [DATA_W-1:0]   ifu_rdata_reg;
  logic                ifu_err_reg;
  logic                lsu_resp_valid_reg;
  logic [DATA_W-1:0]   lsu_rdata_reg;
  logic                lsu_err_reg;

  logic                grant_ifu;
  logic                timeout_hit;
  logic [DATA_W-1:0]   resp_data;

  // Round-robin: on a tie the master that did not win last time gets the port;
  // a lone requester always wins.
  assign grant_ifu = i_ifu_req && (!i_lsu_req || !last_owner_ifu_reg);

  // The >= keeps the watchdog armed even if a handshake lands exactly on the
  // boundary cycle and the counter moves past TIMEOUT-1 while in WAIT.
  assign timeout_hit = (TIMEOUT != 0) &&
                       (32'(cnt_reg) >= 32'(TIMEOUT - 1));

  // Writes return zero data; reads return whatever the slave supplies.
  assign resp_data = wen_reg ? '0 : i_mem_rdata;

  // Arbitration FSM with registered slave-side and response outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg          <= IDLE;
      owner_ifu_reg      <= 1'b0;
      last_owner_ifu_reg <= 1'b0;
      cnt_reg            <= '0;
      addr_reg           <= '0;
      wen_reg            <= 1'b0;
      wdata_reg          <= '0;
      wmask_reg          <= '0;
      mem_req_valid_reg  <= 1'b0;
      ifu_resp_valid_reg <= 1'b0;
      ifu_rdata_reg      <= '0;
      ifu_err_reg        <= 1'b0;
      lsu_resp_valid_reg <= 1'b0;
      lsu_rdata_reg      <= '0;
      lsu_err_reg        <= 1'b0;
    end else begin
      // Response outputs are single-cycle pulses; zero unless set below.
      ifu_resp_valid_reg <= 1'b0;
      ifu_rdata_reg      <= '0;
      ifu_err_reg        <= 1'b0;
      lsu_resp_valid_reg <= 1'b0;
      lsu_rdata_reg      <= '0;
      lsu_err_reg        <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (i_ifu_req || i_lsu_req) begin
            owner_ifu_reg      <= grant_ifu;
            last_owner_ifu_reg <= grant_ifu;
            cnt_reg            <= '0;
            addr_reg           <= grant_ifu ? i_ifu_addr : i_lsu_addr;
            wen_reg            <= grant_ifu ? 1'b0 : i_lsu_wen;
            wdata_reg          <= grant_ifu ? '0 : i_lsu_wdata;
            wmask_reg          <= grant_ifu ? '0 : i_lsu_wmask;
            mem_req_valid_reg  <= 1'b1;
            state_reg          <= REQ;
          end
        end

        REQ: begin
          if (i_mem_req_ready) begin
            mem_req_valid_reg <= 1'b0;
            state_reg         <= WAIT;
          end else if (timeout_hit) begin
            mem_req_valid_reg  <= 1'b0;
            ifu_resp_valid_reg <= owner_ifu_reg;
            ifu_err_reg        <= owner_ifu_reg;
            lsu_resp_valid_reg <= !owner_ifu_reg;
            lsu_err_reg        <= !owner_ifu_reg;
            state_reg          <= RESP;
          end
          if (cnt_reg != '1) cnt_reg <= cnt_reg + CNT_W'(1);
        end

        WAIT: begin
          if (i_mem_resp_valid) begin
            ifu_resp_valid_reg <= owner_ifu_reg;
            ifu_rdata_reg      <= owner_ifu_reg ? resp_data : '0;
            lsu_resp_valid_reg <= !owner_ifu_reg;
            lsu_rdata_reg      <= owner_ifu_reg ? '0 : resp_data;
            state_reg          <= RESP;
          end else if (timeout_hit) begin
            ifu_resp_valid_reg <= owner_ifu_reg;
            ifu_err_reg        <= owner_ifu_reg;
            lsu_resp_valid_reg <= !owner_ifu_reg;
            lsu_err_reg        <= !owner_ifu_reg;
            state_reg          <= RESP;
          end
          if (cnt_reg != '1) cnt_reg <= cnt_reg + CNT_W'(1);
        end

        RESP: begin
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_mem_req_valid  = mem_req_valid_reg;
  assign o_mem_addr       = addr_reg;
  assign o_mem_wen        = wen_reg;
  assign o_mem_wdata      = wdata_reg;
  assign o_mem_wmask      = wmask_reg;
  assign o_ifu_resp_valid = ifu_resp_valid_reg;
  assign o_ifu_rdata      = ifu_rdata_reg;
  assign o_ifu_err        = ifu_err_reg;
  assign o_lsu_resp_valid = lsu_resp_valid_reg;
  assign o_lsu_rdata      = lsu_rdata_reg;
  assign o_lsu_err        = lsu_err_reg;

endmodule
